// File: rtl/alarm_sequencer_if.sv
// Sensor levels into the alarm sequencer and buzzer/mute drive out of it.
interface alarm_sequencer_if;
    logic sLuz;
    logic sPrta;
    logic sIgn;
    logic sAlr;
    logic sMute;

    modport master (
        output sLuz,
        output sPrta,
        output sIgn,
        input  sAlr,
        input  sMute
    );

    modport slave (
        input  sLuz,
        input  sPrta,
        input  sIgn,
        output sAlr,
        output sMute
    );
endinterface

// File: rtl/alarm_sequencer.sv
// Timed, pulsed alarm drive for the lights-on / door-open / ignition-off warning,
// with arming delay, on/off beep cadence and auto-mute after MAX_BEEPS beeps.
module alarm_sequencer #(
    parameter int unsigned DELAY_CYC = 4,
    parameter int unsigned ON_CYC    = 3,
    parameter int unsigned OFF_CYC   = 2,
    parameter int unsigned MAX_BEEPS = 5
) (
    input  logic               clk,
    input  logic               reset,
    alarm_sequencer_if.slave   bus
);

    localparam int unsigned M1   = (DELAY_CYC > ON_CYC) ? DELAY_CYC : ON_CYC;
    localparam int unsigned MAXC = (M1 > OFF_CYC) ? M1 : OFF_CYC;
    localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int unsigned BW   = $clog2(MAX_BEEPS + 1);

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        BEEP_ON,
        BEEP_OFF,
        MUTE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic [BW-1:0]   nbeep_q, nbeep_d;
    logic            cond_q;
    logic            cond;

    assign cond = bus.sLuz & bus.sPrta & ~bus.sIgn;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            nbeep_q <= '0;
            cond_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nbeep_q <= nbeep_d;
            cond_q  <= cond;
        end
    end

    // A dropped condition is tested first in every active state so it beats timer expiry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nbeep_d = nbeep_q;
        unique case (state_q)
            IDLE: begin
                if (cond_q) begin
                    state_d = DELAY;
                    nbeep_d = '0;
                end
            end
            DELAY: begin
                if (!cond_q) begin
                    state_d = IDLE;
                end else if (cnt_q == CW'(DELAY_CYC - 1)) begin
                    state_d = BEEP_ON;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BEEP_ON: begin
                if (!cond_q) begin
                    state_d = IDLE;
                end else if (cnt_q == CW'(ON_CYC - 1)) begin
                    nbeep_d = nbeep_q + 1'b1;
                    state_d = (nbeep_d == BW'(MAX_BEEPS)) ? MUTE : BEEP_OFF;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BEEP_OFF: begin
                if (!cond_q) begin
                    state_d = IDLE;
                end else if (cnt_q == CW'(OFF_CYC - 1)) begin
                    state_d = BEEP_ON;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MUTE: begin
                if (!cond_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    assign bus.sAlr  = (state_q == BEEP_ON);
    assign bus.sMute = (state_q == MUTE);

endmodule

// File: tb/tb_alarm_sequencer.sv
// Randomised and directed bench for alarm_sequencer with a queue-based scoreboard.
module tb_alarm_sequencer;

    localparam int unsigned D   = 4;
    localparam int unsigned ON  = 3;
    localparam int unsigned OFF = 2;
    localparam int unsigned MB  = 5;

    logic clk = 1'b0;
    logic reset;

    alarm_sequencer_if bus();

    alarm_sequencer #(
        .DELAY_CYC (D),
        .ON_CYC    (ON),
        .OFF_CYC   (OFF),
        .MAX_BEEPS (MB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [1:0]  expq[$];
    bit          mcq;
    int unsigned run;

    // Outputs after an edge, from whether the sampled condition was set before that
    // edge and for how many consecutive edges it had been set.
    function automatic logic [1:0] expect_out(bit cq, int unsigned r);
        int unsigned e;
        int unsigned p;
        if (!cq) return 2'b00;
        e = r - 1;
        if (e < D) return 2'b00;
        p = e - D;
        if (p >= MB * ON + (MB - 1) * OFF) return 2'b01;
        if ((p % (ON + OFF)) < ON) return 2'b10;
        return 2'b00;
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit c;
        if (reset) begin
            mcq = 1'b0;
            run = 0;
            expq.push_back(2'b00);
        end else begin
            expq.push_back(expect_out(mcq, run));
            c   = bus.sLuz & bus.sPrta & ~bus.sIgn;
            run = c ? run + 1 : 0;
            mcq = c;
        end
    end

    always @(negedge clk) begin
        logic [1:0] e;
        if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_underflow: got empty queue expected entry at %0t", $time);
        end else begin
            e = expq.pop_front();
            if (reset) e = 2'b00;
            check("sAlr", bus.sAlr, e[1]);
            check("sMute", bus.sMute, e[0]);
        end
    end

    task automatic drive(input bit l, input bit p, input bit i, input int n);
        bus.sLuz  = l;
        bus.sPrta = p;
        bus.sIgn  = i;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        bus.sLuz  = 1'b0;
        bus.sPrta = 1'b0;
        bus.sIgn  = 1'b0;
        #1;
        check("reset_sAlr", bus.sAlr, 1'b0);
        check("reset_sMute", bus.sMute, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // full sequence into mute
        drive(1, 1, 0, 40);
        drive(0, 0, 0, 5);
        // early abort during arming delay, then full re-arm
        drive(1, 1, 0, 3);
        drive(1, 0, 0, 4);
        drive(1, 1, 0, 12);
        // ignition on during the second beep
        drive(0, 0, 0, 3);
        drive(1, 1, 0, 11);
        drive(1, 1, 1, 3);
        drive(1, 1, 0, 20);
        // one-cycle lights-off while muted
        drive(1, 1, 0, 40);
        drive(0, 1, 0, 1);
        drive(1, 1, 0, 40);

        // asynchronous reset in the middle of a beep
        drive(0, 0, 0, 3);
        drive(1, 1, 0, 6);
        check("pre_reset_sAlr", bus.sAlr, 1'b1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_reset_sAlr", bus.sAlr, 1'b0);
        check("async_reset_sMute", bus.sMute, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        drive(1, 1, 0, 40);

        // sub-cycle glitch between edges
        drive(0, 0, 0, 3);
        #1 bus.sLuz = 1'b1; bus.sPrta = 1'b1;
        #2 bus.sLuz = 1'b0; bus.sPrta = 1'b0;
        drive(0, 0, 0, 8);

        // every sensor combination held
        for (int c = 0; c < 8; c++) begin
            bit [2:0] cb;
            cb = c[2:0];
            drive(cb[2], cb[1], cb[0], 40);
            drive(0, 0, 0, 2);
        end

        // random segments, biased toward long warning holds
        for (int s = 0; s < 80; s++) begin
            if ($urandom_range(0, 2) == 0)
                drive(1, 1, 0, int'($urandom_range(1, 45)));
            else
                drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), int'($urandom_range(1, 12)));
        end

        drive(0, 0, 0, 2);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
